score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter KOMI_HALF, default 13, meaning komi in half-points (8-bit, 0..255; 13 = 6.5).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum cycles to wait for terr_ready after update_pulse (16-bit).
REQ-003 The block SHALL have port clk_in, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_in, input, 1, meaning the synchronous active-high reset.
REQ-005 The block SHALL have port score_req, input, 1, meaning a request to score the current board.
REQ-006 The block SHALL have port update_pulse, output, 1, meaning the start strobe to the territory counter.
REQ-007 The block SHALL have port terr_ready, input, 1, meaning the territory counter's done strobe.
REQ-008 The block SHALL have ports bcount_in and wcount_in, input, 8 each, meaning black/white area counts (stones + territory, 0..81).
REQ-009 The block SHALL have port busy, output, 1, meaning a request is in progress.
REQ-010 The block SHALL have port score_valid, output, 1, meaning a one-cycle strobe that new results are present.
REQ-011 The block SHALL have ports black_score_out and white_score_out, output, 9 each, meaning final scores in half-points.
REQ-012 The block SHALL have port winner_out, output, 2, meaning 01 black, 10 white, 00 tie.
REQ-013 The block SHALL have port margin_out, output, 9, meaning |black - white| in half-points.
REQ-014 The block SHALL have port timeout_out, output, 1, meaning a sticky flag that the last request timed out.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, COMPUTE, DONE.
REQ-016 IDLE: score_req high SHALL move to REQ, clear timeout_out and assert busy.
REQ-017 REQ: update_pulse SHALL be high for exactly this one cycle, then the FSM moves to WAIT with the timeout counter at 0.
REQ-018 WAIT: terr_ready high SHALL latch bcount_in/wcount_in and move to COMPUTE; otherwise the counter increments.
REQ-019 WAIT: counter reaching TIMEOUT_CYCLES without terr_ready SHALL set timeout_out, move to IDLE, leave result outputs unchanged and not assert score_valid.
REQ-020 COMPUTE: black = 2*bcount and white = 2*wcount (+KOMI_HALF per REQ-029) SHALL be registered, with winner and margin, using 9-bit unsigned arithmetic (max 417, no overflow).
REQ-021 DONE: score_valid SHALL be high for one cycle, then the FSM returns to IDLE and busy deasserts.
REQ-022 Latency: score_req sampled at edge N gives update_pulse in cycle N+1; terr_ready sampled at edge M gives score_valid high in the cycle after edge M+2.
REQ-023 score_req SHALL be ignored while busy; no queuing.
REQ-024 terr_ready SHALL be ignored outside WAIT; terr_ready arriving in the same cycle as the counter limit SHALL be accepted (success wins).
REQ-025 Equal scores SHALL give winner_out 00 and margin_out 0.
REQ-026 Result outputs SHALL hold their values until the next successful DONE.

Reset
REQ-027 rst_in SHALL force IDLE and zero every output: update_pulse, busy, score_valid, scores, winner_out, margin_out, timeout_out.
REQ-028 rst_in mid-request SHALL abort without a score_valid strobe; a later terr_ready SHALL be ignored.

Configuration
REQ-029 With macro SCORE_KOMI_EN defined, white score SHALL include +KOMI_HALF; without it, komi SHALL be 0 and KOMI_HALF SHALL be unused.

Structure
REQ-030 The shared package go_pkg SHALL hold color constants (EMPTY 2'b00, B 2'b01, W 2'b10), the winner encoding, and the FSM state typedef.
REQ-031 Comparison and margin SHALL live in combinational sub-module score_compare (two 9-bit in; winner, margin out).

Verification
REQ-032 Request, terr_ready after 5 cycles with b=40, w=41, SCORE_KOMI_EN, KOMI_HALF=13 -> black 80, white 95, winner 10, margin 15, one score_valid.
REQ-033 Same counts without SCORE_KOMI_EN -> white 82, winner 10, margin 2; b=w=40 -> winner 00, margin 0.
REQ-034 No terr_ready, TIMEOUT_CYCLES=8 -> timeout_out after 8 WAIT cycles, no score_valid, prior results held; next request clears timeout_out.
REQ-035 score_req held high 20 cycles -> exactly one update_pulse per request; stray terr_ready in IDLE -> no activity.
REQ-036 rst_in asserted in WAIT, then terr_ready -> all outputs 0, no score_valid; b=81, w=0 with komi 255 -> white 255, black 162, winner 10, margin 93.

Source files
------------

// File: rtl/go_pkg.sv
// Shared Go scoring definitions: board colours, result encoding, scorer FSM states.
package go_pkg;

  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned SCORE_W  = 9;
  localparam int unsigned TIMER_W  = 16;
  localparam int unsigned WINNER_W = 2;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] B     = 2'b01;
  localparam logic [1:0] W     = 2'b10;

  typedef enum logic [WINNER_W-1:0] {
    WIN_TIE   = 2'b00,
    WIN_BLACK = 2'b01,
    WIN_WHITE = 2'b10
  } winner_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    COMPUTE,
    DONE
  } state_t;

  typedef struct packed {
    logic [SCORE_W-1:0] black;
    logic [SCORE_W-1:0] white;
    winner_t            winner;
    logic [SCORE_W-1:0] margin;
  } result_t;

  // Area count (points) to half-points, widened so 2*81 plus komi fits.
  function automatic logic [SCORE_W-1:0] area_to_half(input logic [COUNT_W-1:0] area);
    return {area, 1'b0};
  endfunction

endpackage

// File: rtl/score_compare.sv
// Combinational winner decision and absolute margin between two half-point scores.
module score_compare
  import go_pkg::*;
(
  input  logic [SCORE_W-1:0] black,
  input  logic [SCORE_W-1:0] white,
  output winner_t            winner_c,
  output logic [SCORE_W-1:0] margin_c
);

  always_comb begin
    winner_c = WIN_TIE;
    margin_c = '0;
    if (black > white) begin
      winner_c = WIN_BLACK;
      margin_c = black - white;
    end else if (white > black) begin
      winner_c = WIN_WHITE;
      margin_c = white - black;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Go score keeper: strobes the territory counter, waits (bounded) for its result, and
// registers final scores, winner and margin. Komi is added only when SCORE_KOMI_EN is defined.
module score_keeper
  import go_pkg::*;
#(
  parameter int unsigned KOMI_HALF      = 13,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               score_req,
  output logic               update_pulse,
  input  logic               terr_ready,
  input  logic [COUNT_W-1:0] bcount_in,
  input  logic [COUNT_W-1:0] wcount_in,
  output logic               busy,
  output logic               score_valid,
  output logic [SCORE_W-1:0] black_score_out,
  output logic [SCORE_W-1:0] white_score_out,
  output logic [WINNER_W-1:0] winner_out,
  output logic [SCORE_W-1:0] margin_out,
  output logic               timeout_out
);

  // Elaboration-time range checks on the configuration.
  if (KOMI_HALF > 255) begin : g_komi_range
    $error("KOMI_HALF must fit in 8 bits");
  end
  if (TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must fit in 16 bits");
  end

`ifdef SCORE_KOMI_EN
  localparam logic [SCORE_W-1:0] KOMI = SCORE_W'(KOMI_HALF);
`else
  localparam logic [SCORE_W-1:0] KOMI = '0;
`endif

  localparam logic [TIMER_W:0] TIMEOUT_LIMIT = (TIMER_W+1)'(TIMEOUT_CYCLES);

  state_t             state;
  logic [TIMER_W-1:0] wait_cnt;
  logic [COUNT_W-1:0] b_lat;
  logic [COUNT_W-1:0] w_lat;
  logic [SCORE_W-1:0] black_c;
  logic [SCORE_W-1:0] white_c;
  winner_t            winner_c;
  logic [SCORE_W-1:0] margin_c;
  logic               timeout_hit_c;
  result_t            result_c;

  assign black_c = area_to_half(b_lat);
  assign white_c = area_to_half(w_lat) + KOMI;

  // Limit reached on the WAIT cycle whose increment would hit TIMEOUT_CYCLES.
  assign timeout_hit_c = ({1'b0, wait_cnt} + (TIMER_W+1)'(1)) >= TIMEOUT_LIMIT;

  score_compare u_compare (
    .black    (black_c),
    .white    (white_c),
    .winner_c (winner_c),
    .margin_c (margin_c)
  );

  assign result_c = '{black: black_c, white: white_c, winner: winner_c, margin: margin_c};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      b_lat           <= '0;
      w_lat           <= '0;
      update_pulse    <= 1'b0;
      busy            <= 1'b0;
      score_valid     <= 1'b0;
      black_score_out <= '0;
      white_score_out <= '0;
      winner_out      <= '0;
      margin_out      <= '0;
      timeout_out     <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      score_valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (score_req) begin
            state        <= REQ;
            busy         <= 1'b1;
            timeout_out  <= 1'b0;
            update_pulse <= 1'b1;
          end
        end
        REQ: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // A ready strobe on the limit cycle still counts as success.
          if (terr_ready) begin
            b_lat <= bcount_in;
            w_lat <= wcount_in;
            state <= COMPUTE;
          end else if (timeout_hit_c) begin
            timeout_out <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TIMER_W'(1);
          end
        end
        COMPUTE: begin
          black_score_out <= result_c.black;
          white_score_out <= result_c.white;
          winner_out      <= result_c.winner;
          margin_out      <= result_c.margin;
          state           <= DONE;
        end
        DONE: begin
          score_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper with a points-level scoring model.
module tb_score_keeper;

  localparam int unsigned KOMI_HALF = 13;
  localparam int unsigned TIMEOUT   = 8;
`ifdef SCORE_KOMI_EN
  localparam int KOMI_EFF = KOMI_HALF;
`else
  localparam int KOMI_EFF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_in;
  logic       score_req;
  logic       terr_ready;
  logic [7:0] bcount_in;
  logic [7:0] wcount_in;
  logic       update_pulse;
  logic       busy;
  logic       score_valid;
  logic [8:0] black_score_out;
  logic [8:0] white_score_out;
  logic [1:0] winner_out;
  logic [8:0] margin_out;
  logic       timeout_out;

  int checks = 0;
  int errors = 0;
  int sv_count = 0;
  int up_count = 0;

  // Last successfully published result (zero after reset).
  int exp_black = 0;
  int exp_white = 0;
  int exp_winner = 0;
  int exp_margin = 0;

  score_keeper #(.KOMI_HALF(KOMI_HALF), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .score_req       (score_req),
    .update_pulse    (update_pulse),
    .terr_ready      (terr_ready),
    .bcount_in       (bcount_in),
    .wcount_in       (wcount_in),
    .busy            (busy),
    .score_valid     (score_valid),
    .black_score_out (black_score_out),
    .white_score_out (white_score_out),
    .winner_out      (winner_out),
    .margin_out      (margin_out),
    .timeout_out     (timeout_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (score_valid === 1'b1) sv_count++;
    if (update_pulse === 1'b1) up_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1);
  end

  // Go area scoring: each point is two half-points, white gets komi, ties have no winner.
  function automatic void model(input int b, input int w,
                                output int eb, output int ew, output int ewin, output int em);
    eb = 2 * b;
    ew = 2 * w + KOMI_EFF;
    if (eb > ew) begin ewin = 1; em = eb - ew; end
    else if (ew > eb) begin ewin = 2; em = ew - eb; end
    else begin ewin = 0; em = 0; end
  endfunction

  task automatic check_held(input string name);
    checks++;
    if (black_score_out !== 9'(exp_black) || white_score_out !== 9'(exp_white) ||
        winner_out !== 2'(exp_winner) || margin_out !== 9'(exp_margin)) begin
      errors++;
      $display("FAIL %s: got b=%0d w=%0d win=%0d m=%0d required b=%0d w=%0d win=%0d m=%0d", name,
               black_score_out, white_score_out, winner_out, margin_out,
               exp_black, exp_white, exp_winner, exp_margin);
    end
  endtask

  // One full request; terr_ready is driven d cycles after the update_pulse cycle (1..TIMEOUT).
  task automatic run_request(input int b, input int w, input int d, input string name);
    int eb, ew, ewin, em, sv0;
    model(b, w, eb, ew, ewin, em);
    sv0 = sv_count;
    score_req = 1'b1;
    @(negedge clk);
    score_req = 1'b0;
    checks++;
    if (update_pulse !== 1'b1 || busy !== 1'b1 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: got up=%b busy=%b to=%b required 1 1 0", name, update_pulse, busy, timeout_out);
    end
    repeat (d) @(negedge clk);
    checks++;
    if (update_pulse !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s wait: got up=%b busy=%b required 0 1", name, update_pulse, busy);
    end
    terr_ready = 1'b1;
    bcount_in = 8'(b);
    wcount_in = 8'(w);
    @(negedge clk);
    terr_ready = 1'b0;
    bcount_in = 8'($urandom_range(0, 81));
    wcount_in = 8'($urandom_range(0, 81));
    @(negedge clk);
    checks++;
    if (score_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s early valid: got valid=%b busy=%b required 0 1", name, score_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (score_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s valid: got valid=%b busy=%b required 1 0", name, score_valid, busy);
    end
    exp_black = eb; exp_white = ew; exp_winner = ewin; exp_margin = em;
    check_held({name, " result"});
    @(negedge clk);
    checks++;
    if (score_valid !== 1'b0 || sv_count - sv0 != 1) begin
      errors++;
      $display("FAIL %s strobe count: got valid=%b count=%0d required 0 1", name, score_valid, sv_count - sv0);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; score_req = 1'b0; terr_ready = 1'b0; bcount_in = '0; wcount_in = '0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    checks++;
    if (update_pulse !== 1'b0 || busy !== 1'b0 || score_valid !== 1'b0 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl: got up=%b busy=%b valid=%b to=%b required 0 0 0 0",
               update_pulse, busy, score_valid, timeout_out);
    end
    check_held("reset result");
  endtask

  task automatic test_latency();
    run_request(40, 41, 5, "b40_w41");
  endtask

  task automatic test_tie();
    run_request(40, 40, 3, "b40_w40");
  endtask

  task automatic test_boundary();
    run_request(81, 0, TIMEOUT, "b81_w0_limit");
    run_request(0, 0, 1, "b0_w0");
    run_request(0, 81, 2, "b0_w81");
  endtask

  task automatic test_timeout();
    int sv0;
    sv0 = sv_count;
    score_req = 1'b1;
    @(negedge clk);
    score_req = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    checks++;
    if (timeout_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout early: got to=%b busy=%b required 0 1", timeout_out, busy);
    end
    @(negedge clk);
    checks++;
    if (timeout_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout flag: got to=%b busy=%b required 1 0", timeout_out, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sv_count != sv0 || timeout_out !== 1'b1) begin
      errors++;
      $display("FAIL timeout no valid: got strobes=%0d to=%b required 0 1", sv_count - sv0, timeout_out);
    end
    check_held("timeout held");
    run_request(12, 30, 4, "after_timeout");
  endtask

  task automatic test_held_req();
    int up0, expected;
    up0 = up_count;
    expected = (20 + (TIMEOUT + 2) - 1) / (TIMEOUT + 2);
    score_req = 1'b1;
    repeat (20) @(negedge clk);
    score_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (up_count - up0 != expected || busy !== 1'b0) begin
      errors++;
      $display("FAIL held req pulses: got %0d busy=%b required %0d 0", up_count - up0, busy, expected);
    end
  endtask

  task automatic test_stray();
    int up0, sv0;
    up0 = up_count; sv0 = sv_count;
    terr_ready = 1'b1;
    bcount_in = 8'd77; wcount_in = 8'd3;
    repeat (3) @(negedge clk);
    terr_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (up_count != up0 || sv_count != sv0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray ready: got up=%0d valid=%0d busy=%b required 0 0 0",
               up_count - up0, sv_count - sv0, busy);
    end
    check_held("stray held");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_request(int'($urandom_range(0, 81)), int'($urandom_range(0, 81)),
                  int'($urandom_range(1, TIMEOUT)), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_request(33, 29, 1, "b2b_first");
    run_request(29, 33, 1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int sv0;
    score_req = 1'b1;
    @(negedge clk);
    score_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    sv0 = sv_count;
    terr_ready = 1'b1; bcount_in = 8'd50; wcount_in = 8'd10;
    @(negedge clk);
    terr_ready = 1'b0;
    repeat (4) @(negedge clk);
    exp_black = 0; exp_white = 0; exp_winner = 0; exp_margin = 0;
    checks++;
    if (sv_count != sv0 || busy !== 1'b0 || update_pulse !== 1'b0 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset mid: got strobes=%0d busy=%b up=%b to=%b required 0 0 0 0",
               sv_count - sv0, busy, update_pulse, timeout_out);
    end
    check_held("reset mid result");
  endtask

  initial begin
    rst_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_tie();
    test_boundary();
    test_timeout();
    test_held_req();
    test_stray();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
